// File: rtl/aes_result_display_if.sv
// Bus between the AES result source and the byte-by-byte BCD display stage.
// load is a one-cycle capture strobe; step is a level whose 0->1 transitions request the next byte.
interface aes_result_display_if;
  logic         load;
  logic [127:0] data_in;
  logic         step;
  logic         busy;
  logic [3:0]   byte_idx;
  logic [11:0]  bcd;
  logic [6:0]   hex0;
  logic [6:0]   hex1;
  logic [6:0]   hex2;
  logic [1:0]   fsm_state;

  modport master (
    output load, data_in, step,
    input  busy, byte_idx, bcd, hex0, hex1, hex2, fsm_state
  );

  modport slave (
    input  load, data_in, step,
    output busy, byte_idx, bcd, hex0, hex1, hex2, fsm_state
  );
endinterface

// File: rtl/aes_result_display.sv
// Captures a 128-bit AES result and converts one selected byte at a time to three
// BCD digits (8-cycle double-dabble) driven onto active-low 7-segment displays.
module aes_result_display #(
  parameter int NUM_BYTES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_result_display_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t         state_q;
  logic [127:0]   data_q;
  logic [3:0]     idx_q;
  logic [19:0]    work_q;
  logic [3:0]     iter_q;
  logic [11:0]    bcd_q;
  logic [6:0]     hex0_q;
  logic [6:0]     hex1_q;
  logic [6:0]     hex2_q;
  logic           busy_q;
  logic           step_q;

  logic           step_edge;
  logic [3:0]     idx_d;
  logic [7:0]     byte_d;
  logic [19:0]    work_d;

  // One shift-add-3 iteration on {bcd_work[11:0], bin[7:0]}.
  function automatic logic [19:0] dd_iter(input logic [19:0] w);
    logic [19:0] a;
    a = w;
    for (int i = 0; i < 3; i++) begin
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    step_edge = bus.step & ~step_q;
    idx_d     = (idx_q == 4'(NUM_BYTES - 1)) ? 4'd0 : idx_q + 4'd1;
    byte_d    = data_q[{idx_d, 3'b000} +: 8];
    work_d    = dd_iter(work_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      work_q  <= '0;
      iter_q  <= '0;
      bcd_q   <= 12'h000;
      hex0_q  <= 7'h7F;
      hex1_q  <= 7'h7F;
      hex2_q  <= 7'h7F;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      step_q <= bus.step;
      // load overrides everything, including an in-flight conversion and a coincident step.
      if (bus.load) begin
        data_q  <= bus.data_in;
        idx_q   <= '0;
        work_q  <= {12'h000, bus.data_in[7:0]};
        iter_q  <= '0;
        busy_q  <= 1'b1;
        state_q <= CONV;
      end else begin
        case (state_q)
          IDLE: begin
          end
          CONV: begin
            work_q <= work_d;
            iter_q <= iter_q + 4'd1;
            if (iter_q == 4'd7) begin
              bcd_q   <= work_d[19:8];
              hex0_q  <= seg(work_d[11:8]);
              hex1_q  <= seg(work_d[15:12]);
              hex2_q  <= seg(work_d[19:16]);
              busy_q  <= 1'b0;
              state_q <= SHOW;
            end
          end
          SHOW: begin
            if (step_edge) begin
              idx_q   <= idx_d;
              work_q  <= {12'h000, byte_d};
              iter_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= CONV;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.byte_idx  = idx_q;
  assign bus.bcd       = bcd_q;
  assign bus.hex0      = hex0_q;
  assign bus.hex1      = hex1_q;
  assign bus.hex2      = hex2_q;
  assign bus.fsm_state = state_q;

endmodule
